fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between an upstream FIFO and the UART transmitter.
// master = transmitter (issues read strobes), slave = FIFO (supplies flag and data).
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_r_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_r_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a registered-read FIFO and serialises them
// as start / LSB-first data / stop, with all outputs registered.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic           rclk,
    input  logic           rst_n,
    input  logic           tx_enable,
    fifo_uart_tx_if.master fifo,
    output logic           txd,
    output logic           busy,
    output logic           tx_done
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  r_en_q, r_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic start_frame;
    logic baud_end;

    assign start_frame = tx_enable && !fifo.fifo_empty;
    assign baud_end    = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // FIFO read data is valid now, one cycle after the strobe.
                shift_d = fifo.fifo_data;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                // The bit counter is reused to count stop bits.
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = start_frame ? READ : IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registers line up with state_q.
    always_comb begin
        txd_d  = 1'b1;
        r_en_d = (state_d == READ);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            r_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            r_en_q  <= r_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.fifo_r_en = r_en_q;
    assign txd            = txd_q;
    assign busy           = busy_q;
    assign tx_done        = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit, one with 2 stop bits,
// each fed by a small behavioural registered-read FIFO.
module tb_fifo_uart_tx;
    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic rst_n;
    logic tx_enable;
    logic txd_a, busy_a, done_a;
    logic txd_b, busy_b, done_b;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fa ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fb ();

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .rclk(rclk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo(fa.master),
        .txd(txd_a), .busy(busy_a), .tx_done(done_a)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .rclk(rclk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo(fb.master),
        .txd(txd_b), .busy(busy_b), .tx_done(done_b)
    );

    // Behavioural FIFOs: data registered one cycle after the strobe, flag updated at the edge.
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always @(posedge rclk) begin
        if (fa.fifo_r_en && qa.size() > 0) fa.fifo_data <= qa.pop_front();
        fa.fifo_empty <= (qa.size() == 0);
        if (fb.fifo_r_en && qb.size() > 0) fb.fifo_data <= qb.pop_front();
        fb.fifo_empty <= (qb.size() == 0);
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rd_a   = 0;
    int rd_b   = 0;
    int rd_cyc_a = 0;
    int rd_cyc_b = 0;
    int start_cyc = 0;

    typedef struct {
        logic        sel_b;
        logic [7:0]  data;
        logic [10:0] bits;   // bit i = expected txd level of serial bit i (start first)
        int          nbits;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(negedge rclk);
        cyc++;
        if (fa.fifo_r_en === 1'b1) begin rd_a++; rd_cyc_a = cyc; end
        if (fb.fifo_r_en === 1'b1) begin rd_b++; rd_cyc_b = cyc; end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic txd_s(input logic sel);
        return sel ? txd_b : txd_a;
    endfunction

    function automatic logic done_s(input logic sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic push(input logic sel, input logic [7:0] d);
        if (sel) qb.push_back(d);
        else     qa.push_back(d);
    endtask

    // Waits for the start bit, then checks every cycle of the frame against the expected bits.
    task automatic run_frame(input logic sel, input logic [10:0] bits, input int nbits,
                             input int drop_at, output int gap);
        int t;
        int bad;
        int done_c;
        int done_n;
        gap = 0;
        bad = 0;
        done_c = 0;
        done_n = 0;
        tick();
        t = 1;
        while (txd_s(sel) !== 1'b0 && t < 300) begin
            gap++;
            tick();
            t++;
        end
        if (t >= 300) begin
            chk("start_bit_timeout", 1, 0);
        end else begin
            start_cyc = cyc;
            for (int c = 1; c <= nbits * 4; c++) begin
                if (c > 1) tick();
                if (txd_s(sel) !== bits[(c - 1) / 4]) bad++;
                if (done_s(sel) === 1'b1) begin done_c = c; done_n++; end
                if (c == drop_at) tx_enable = 1'b0;
            end
            chk("frame_bit_errors", bad, 0);
            chk("tx_done_cycle", done_c, nbits * 4);
            chk("tx_done_count", done_n, 1);
        end
    endtask

    initial begin
        int r0;
        int gap;
        int first_rd;
        int bad_t;
        int bad_b;
        int bad_r;

        vecs[0] = '{1'b0, 8'hA5, 11'b01_10100101_0, 10};
        vecs[1] = '{1'b0, 8'h81, 11'b01_10000001_0, 10};
        vecs[2] = '{1'b0, 8'h55, 11'b01_01010101_0, 10};
        vecs[3] = '{1'b0, 8'h0F, 11'b01_00001111_0, 10};
        vecs[4] = '{1'b1, 8'h3C, 11'b11_00111100_0, 11};

        rst_n = 1'b0;
        tx_enable = 1'b0;
        repeat (3) tick();
        chk("reset_txd", int'(txd_a), 1);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_r_en", int'(fa.fifo_r_en), 0);
        chk("reset_tx_done", int'(done_a), 0);
        chk("reset_txd_b", int'(txd_b), 1);

        rst_n = 1'b1;
        tx_enable = 1'b1;
        repeat (2) tick();

        // Single frames from idle, one per table entry.
        for (int i = 0; i < 5; i++) begin
            r0 = vecs[i].sel_b ? rd_b : rd_a;
            push(vecs[i].sel_b, vecs[i].data);
            $display("vector %0d: data 0x%02h, %0d bits", i, vecs[i].data, vecs[i].nbits);
            run_frame(vecs[i].sel_b, vecs[i].bits, vecs[i].nbits, 0, gap);
            chk("read_pulses", (vecs[i].sel_b ? rd_b : rd_a) - r0, 1);
            chk("read_to_start", start_cyc - (vecs[i].sel_b ? rd_cyc_b : rd_cyc_a), 2);
            tick();
            chk("idle_busy", int'(vecs[i].sel_b ? busy_b : busy_a), 0);
        end

        // Back-to-back frames: 2-cycle gap, reads 42 cycles apart.
        r0 = rd_a;
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        run_frame(1'b0, 11'b01_00000000_0, 10, 0, gap);
        first_rd = rd_cyc_a;
        run_frame(1'b0, 11'b01_11111111_0, 10, 0, gap);
        chk("b2b_gap", gap, 2);
        chk("b2b_read_spacing", rd_cyc_a - first_rd, 42);
        chk("b2b_read_pulses", rd_a - r0, 2);

        // Empty FIFO with enable held: nothing happens.
        repeat (2) tick();
        r0 = rd_a;
        bad_t = 0;
        bad_b = 0;
        repeat (100) begin
            tick();
            if (txd_a !== 1'b1) bad_t++;
            if (busy_a !== 1'b0) bad_b++;
        end
        chk("empty_reads", rd_a - r0, 0);
        chk("empty_txd_low", bad_t, 0);
        chk("empty_busy", bad_b, 0);

        // Enable dropped early in the frame: frame completes, no further reads.
        r0 = rd_a;
        push(1'b0, 8'h5A);
        push(1'b0, 8'h33);
        run_frame(1'b0, 11'b01_01011010_0, 10, 5, gap);
        bad_b = 0;
        repeat (60) begin
            tick();
            if (busy_a !== 1'b0) bad_b++;
        end
        chk("drop_en_reads", rd_a - r0, 1);
        chk("drop_en_busy", bad_b, 0);
        chk("drop_en_queue_left", qa.size(), 1);
        tx_enable = 1'b1;
        run_frame(1'b0, 11'b01_00110011_0, 10, 0, gap);
        chk("reenable_reads", rd_a - r0, 2);

        // Reset pulse in the middle of DATA.
        repeat (3) tick();
        push(1'b0, 8'hC3);
        bad_t = 0;
        while (txd_a !== 1'b0 && bad_t < 50) begin
            tick();
            bad_t++;
        end
        chk("rst_frame_started", int'(txd_a), 0);
        repeat (10) tick();
        chk("rst_in_data_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        r0 = rd_a;
        tick();
        chk("rst_mid_txd", int'(txd_a), 1);
        chk("rst_mid_busy", int'(busy_a), 0);
        chk("rst_mid_r_en", int'(fa.fifo_r_en), 0);
        rst_n = 1'b1;
        bad_r = 0;
        repeat (10) begin
            tick();
            if (busy_a !== 1'b0) bad_r++;
        end
        chk("rst_byte_lost", bad_r + (rd_a - r0), 0);
        push(1'b0, 8'h96);
        run_frame(1'b0, 11'b01_10010110_0, 10, 0, gap);
        chk("post_rst_read_to_start", start_cyc - rd_cyc_a, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
